// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl - SPI byte engine for the UPduino configuration flash.
//
// Moves one byte at a time in SPI mode 0, MSB first. SCK runs at
// clk / (2*CLKDIV). The engine and the PIOS bit-bang path share the flash
// pins; the hw_en control bit selects which one drives them.
//
// Ports
//   clk, resetq                 clock, synchronous active-low reset
//   ctrl_wr                     strobe: write control {auto_next, hw_en, cs_assert}
//                               from wdata[2:0]; wdata[15] clears ovr
//   data_wr                     strobe: transmit wdata[7:0]
//   data_rd                     strobe: CPU consumed rx_data; with auto_next=1
//                               it also starts a 0xFF dummy transfer
//   wdata[15:0]                 CPU write data
//   status[15:0]                {11'd0, hw_en, auto_next, ovr, rx_valid, busy}
//   rx_data[7:0]                last received byte
//   pio_sck/pio_mosi/pio_cs_n   bit-bang requester
//   spi_miso                    flash SDO
//   spi_sck/spi_mosi/spi_cs_n   flash pins
module spi_flash_ctrl #(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        ctrl_wr,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [15:0] wdata,
  output logic [15:0] status,
  output logic [7:0]  rx_data,
  input  logic        pio_sck,
  input  logic        pio_mosi,
  input  logic        pio_cs_n,
  input  logic        spi_miso,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        spi_cs_n
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_ZERO   = {DW{1'b0}};
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t         state_r;
  logic           busy_r;
  logic           rx_valid_r;
  logic           ovr_r;
  logic [7:0]     rx_data_r;
  logic           cs_assert_r;
  logic           hw_en_r;
  logic           auto_next_r;
  logic [7:0]     shreg_r;
  logic           eng_sck_r;
  logic           rxbit_r;
  logic [2:0]     bitcnt_r;
  logic [DW-1:0]  divcnt_r;

  logic           hw_en_next_s;
  logic           auto_next_next_s;
  logic           start_s;
  logic [7:0]     start_byte_s;

  assign status  = {11'd0, hw_en_r, auto_next_r, ovr_r, rx_valid_r, busy_r};
  assign rx_data = rx_data_r;

  // Start decode: a control write in the same idle cycle takes effect first,
  // so the start qualifies against the incoming hw_en/auto_next values.
  always_comb begin
    hw_en_next_s     = hw_en_r;
    auto_next_next_s = auto_next_r;
    start_s          = 1'b0;
    start_byte_s     = 8'h00;
    if (ctrl_wr && !busy_r) begin
      hw_en_next_s     = wdata[1];
      auto_next_next_s = wdata[2];
    end else begin
      hw_en_next_s     = hw_en_r;
      auto_next_next_s = auto_next_r;
    end
    if (!busy_r && hw_en_next_s) begin
      if (data_wr) begin
        start_s      = 1'b1;
        start_byte_s = wdata[7:0];
      end else if (data_rd && auto_next_next_s) begin
        start_s      = 1'b1;
        start_byte_s = 8'hFF;
      end else begin
        start_s      = 1'b0;
      end
    end else begin
      start_s = 1'b0;
    end
  end

  // Pin mux between the engine and the bit-bang path.
  always_comb begin
    if (hw_en_r) begin
      spi_sck  = eng_sck_r;
      spi_mosi = shreg_r[7];
      spi_cs_n = ~cs_assert_r;
    end else begin
      spi_sck  = pio_sck;
      spi_mosi = pio_mosi;
      spi_cs_n = pio_cs_n;
    end
  end

  // Control register, status flags and the mode-0 shift FSM.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      rx_valid_r  <= 1'b0;
      ovr_r       <= 1'b0;
      rx_data_r   <= 8'h00;
      cs_assert_r <= 1'b0;
      hw_en_r     <= 1'b0;
      auto_next_r <= 1'b0;
      shreg_r     <= 8'h00;
      eng_sck_r   <= 1'b0;
      rxbit_r     <= 1'b0;
      bitcnt_r    <= 3'd0;
      divcnt_r    <= DIV_ZERO;
    end else begin
      // Control writes landing mid-transfer are discarded and flagged.
      if (ctrl_wr) begin
        if (busy_r) begin
          ovr_r <= 1'b1;
        end else begin
          cs_assert_r <= wdata[0];
          hw_en_r     <= wdata[1];
          auto_next_r <= wdata[2];
          if (wdata[15]) begin
            ovr_r <= 1'b0;
          end
        end
      end
      if (data_wr && busy_r) begin
        ovr_r <= 1'b1;
      end
      // Consumption clears rx_valid; a completion below overrides it.
      if (data_rd) begin
        rx_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (start_s) begin
            shreg_r   <= start_byte_s;
            busy_r    <= 1'b1;
            bitcnt_r  <= 3'd7;
            divcnt_r  <= DIV_RELOAD;
            eng_sck_r <= 1'b0;
            state_r   <= LOW;
          end
        end
        LOW: begin
          if (divcnt_r == DIV_ZERO) begin
            eng_sck_r <= 1'b1;
            rxbit_r   <= spi_miso;
            divcnt_r  <= DIV_RELOAD;
            state_r   <= HIGH;
          end else begin
            divcnt_r <= divcnt_r - DIV_ONE;
          end
        end
        HIGH: begin
          if (divcnt_r == DIV_ZERO) begin
            eng_sck_r <= 1'b0;
            shreg_r   <= {shreg_r[6:0], rxbit_r};
            if (bitcnt_r == 3'd0) begin
              state_r    <= IDLE;
              busy_r     <= 1'b0;
              rx_data_r  <= {shreg_r[6:0], rxbit_r};
              rx_valid_r <= 1'b1;
            end else begin
              bitcnt_r <= bitcnt_r - 3'd1;
              divcnt_r <= DIV_RELOAD;
              state_r  <= LOW;
            end
          end else begin
            divcnt_r <= divcnt_r - DIV_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          eng_sck_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl - directed test of spi_flash_ctrl.
// dut runs at the default CLKDIV=2 against a small flash model that shifts
// out fl_byte MSB first; dut1 runs at CLKDIV=1 with SDO tied high.
module tb_spi_flash_ctrl;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        ctrl_wr = 1'b0, data_wr = 1'b0, data_rd = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] status;
  logic [7:0]  rx_data;
  logic        pio_sck = 1'b0, pio_mosi = 1'b0, pio_cs_n = 1'b1;
  logic        spi_miso, spi_sck, spi_mosi, spi_cs_n;

  logic        ctrl_wr1 = 1'b0, data_wr1 = 1'b0, data_rd1 = 1'b0;
  logic [15:0] wdata1 = 16'h0000;
  logic [15:0] status1;
  logic [7:0]  rx_data1;
  logic        miso1 = 1'b1;
  logic        sck1, mosi1, cs_n1;

  int checks = 0;
  int failures = 0;

  logic [7:0] fl_byte = 8'h00;
  logic [2:0] fl_cnt = 3'd0;
  logic [7:0] mosi_cap = 8'h00;

  spi_flash_ctrl #(.CLKDIV(2)) dut (
    .clk(clk), .resetq(resetq), .ctrl_wr(ctrl_wr), .data_wr(data_wr),
    .data_rd(data_rd), .wdata(wdata), .status(status), .rx_data(rx_data),
    .pio_sck(pio_sck), .pio_mosi(pio_mosi), .pio_cs_n(pio_cs_n),
    .spi_miso(spi_miso), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n)
  );

  spi_flash_ctrl #(.CLKDIV(1)) dut1 (
    .clk(clk), .resetq(resetq), .ctrl_wr(ctrl_wr1), .data_wr(data_wr1),
    .data_rd(data_rd1), .wdata(wdata1), .status(status1), .rx_data(rx_data1),
    .pio_sck(pio_sck), .pio_mosi(pio_mosi), .pio_cs_n(pio_cs_n),
    .spi_miso(miso1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_cs_n(cs_n1)
  );

  always #5 clk = ~clk;

  // Flash model: presents the current bit of fl_byte, advances on SCK rise
  // while the engine owns the pins, and captures MOSI on the same edge.
  assign spi_miso = fl_byte[3'd7 - fl_cnt];

  always @(posedge spi_sck or negedge resetq) begin
    if (!resetq) begin
      fl_cnt   <= 3'd0;
      mosi_cap <= 8'h00;
    end else if (status[4] === 1'b1) begin
      fl_cnt   <= fl_cnt + 3'd1;
      mosi_cap <= {mosi_cap[6:0], spi_mosi};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ctrl(input logic [15:0] w);
    wdata = w; ctrl_wr = 1'b1; tick(); ctrl_wr = 1'b0;
  endtask

  task automatic do_wr(input logic [15:0] w);
    wdata = w; data_wr = 1'b1; tick(); data_wr = 1'b0;
  endtask

  task automatic do_rd();
    data_rd = 1'b1; tick(); data_rd = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (status[0] === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetq = 1'b0; pio_cs_n = 1'b0; pio_mosi = 1'b1;
    tick(); tick();
    pio_sck = 1'b1; #1;
    checks++; if (spi_sck !== 1'b1) begin failures++; $display("FAIL reset_sck_hi got=%b exp=1", spi_sck); end
    pio_sck = 1'b0; #1;
    checks++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL reset_sck_lo got=%b exp=0", spi_sck); end
    checks++; if (spi_cs_n !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", spi_cs_n); end
    checks++; if (spi_mosi !== 1'b1) begin failures++; $display("FAIL reset_mosi got=%b exp=1", spi_mosi); end
    checks++; if (status !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", status); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
    checks++; if (status1 !== 16'h0000) begin failures++; $display("FAIL reset_status1 got=%h exp=0000", status1); end
    pio_cs_n = 1'b1; pio_mosi = 1'b0; resetq = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    do_ctrl(16'h0003);
    checks++; if (spi_cs_n !== 1'b0) begin failures++; $display("FAIL single_cs got=%b exp=0", spi_cs_n); end
    fl_byte = 8'hA5;
    do_wr(16'h0003);
    checks++; if (status !== 16'h0011) begin failures++; $display("FAIL single_busy got=%h exp=0011", status); end
    wait_idle(n);
    checks++; if (n != 32) begin failures++; $display("FAIL single_len got=%0d exp=32", n); end
    checks++; if (mosi_cap !== 8'h03) begin failures++; $display("FAIL single_mosi got=%h exp=03", mosi_cap); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_rx got=%h exp=a5", rx_data); end
    checks++; if (status !== 16'h0012) begin failures++; $display("FAIL single_status got=%h exp=0012", status); end
  endtask

  task automatic test_stream();
    int n;
    logic [7:0] cmd [4];
    logic [7:0] dat [4];
    cmd[0] = 8'h03; cmd[1] = 8'h01; cmd[2] = 8'h20; cmd[3] = 8'h00;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    do_ctrl(16'h0007);
    fl_byte = 8'h00;
    for (int i = 0; i < 4; i++) begin
      do_wr({8'h00, cmd[i]});
      wait_idle(n);
      checks++; if (mosi_cap !== cmd[i]) begin failures++; $display("FAIL stream_cmd%0d got=%h exp=%h", i, mosi_cap, cmd[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      fl_byte = dat[i];
      do_rd();
      checks++; if (status[0] !== 1'b1) begin failures++; $display("FAIL stream_start%0d got=%b exp=1", i, status[0]); end
      wait_idle(n);
      checks++; if (rx_data !== dat[i]) begin failures++; $display("FAIL stream_rx%0d got=%h exp=%h", i, rx_data, dat[i]); end
      checks++; if (mosi_cap !== 8'hFF) begin failures++; $display("FAIL stream_dummy%0d got=%h exp=ff", i, mosi_cap); end
    end
    do_ctrl(16'h0003);
  endtask

  task automatic test_overrun();
    int n;
    fl_byte = 8'h5A;
    do_wr(16'h00C3);
    repeat (5) tick();
    do_wr(16'h0000);
    do_ctrl(16'h0000);
    checks++; if (spi_cs_n !== 1'b0) begin failures++; $display("FAIL ovr_cs got=%b exp=0", spi_cs_n); end
    wait_idle(n);
    checks++; if (mosi_cap !== 8'hC3) begin failures++; $display("FAIL ovr_mosi got=%h exp=c3", mosi_cap); end
    checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL ovr_rx got=%h exp=5a", rx_data); end
    checks++; if (status !== 16'h0016) begin failures++; $display("FAIL ovr_status got=%h exp=0016", status); end
    do_ctrl(16'h8003);
    checks++; if (status !== 16'h0012) begin failures++; $display("FAIL ovr_clear got=%h exp=0012", status); end
  endtask

  task automatic test_simul();
    int n;
    do_ctrl(16'h0000);
    fl_byte = 8'h96;
    wdata = 16'h0003; ctrl_wr = 1'b1; data_wr = 1'b1; tick(); ctrl_wr = 1'b0; data_wr = 1'b0;
    checks++; if (status !== 16'h0013) begin failures++; $display("FAIL simul_ctrl_start got=%h exp=0013", status); end
    wait_idle(n);
    checks++; if (mosi_cap !== 8'h03) begin failures++; $display("FAIL simul_ctrl_mosi got=%h exp=03", mosi_cap); end
    checks++; if (rx_data !== 8'h96) begin failures++; $display("FAIL simul_ctrl_rx got=%h exp=96", rx_data); end
    do_ctrl(16'h0007);
    wdata = 16'h0081; data_wr = 1'b1; data_rd = 1'b1; tick(); data_wr = 1'b0; data_rd = 1'b0;
    checks++; if (status !== 16'h0019) begin failures++; $display("FAIL simul_rdwr_start got=%h exp=0019", status); end
    wait_idle(n);
    checks++; if (mosi_cap !== 8'h81) begin failures++; $display("FAIL simul_rdwr_mosi got=%h exp=81", mosi_cap); end
    do_ctrl(16'h0003);
  endtask

  task automatic test_rd_complete();
    do_rd();
    checks++; if (status !== 16'h0010) begin failures++; $display("FAIL rdc_clear got=%h exp=0010", status); end
    fl_byte = 8'h3C;
    do_wr(16'h0081);
    repeat (31) tick();
    data_rd = 1'b1; tick(); data_rd = 1'b0;
    checks++; if (status !== 16'h0012) begin failures++; $display("FAIL rdc_status got=%h exp=0012", status); end
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL rdc_rx got=%h exp=3c", rx_data); end
  endtask

  task automatic test_reset_mid();
    pio_cs_n = 1'b1;
    do_wr(16'h0055);
    repeat (9) tick();
    resetq = 1'b0;
    tick();
    checks++; if (status !== 16'h0000) begin failures++; $display("FAIL rmid_status got=%h exp=0000", status); end
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL rmid_cs got=%b exp=1", spi_cs_n); end
    checks++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL rmid_sck got=%b exp=0", spi_sck); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rmid_rx got=%h exp=00", rx_data); end
    pio_cs_n = 1'b0; #1;
    checks++; if (spi_cs_n !== 1'b0) begin failures++; $display("FAIL rmid_cs_follow got=%b exp=0", spi_cs_n); end
    pio_cs_n = 1'b1; resetq = 1'b1;
    tick();
  endtask

  task automatic test_clkdiv1();
    int n;
    wdata1 = 16'h0003; ctrl_wr1 = 1'b1; tick(); ctrl_wr1 = 1'b0;
    wdata1 = 16'h00F0; data_wr1 = 1'b1; tick(); data_wr1 = 1'b0;
    checks++; if (status1 !== 16'h0011) begin failures++; $display("FAIL div1_start got=%h exp=0011", status1); end
    n = 0;
    while (status1[0] === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (n != 16) begin failures++; $display("FAIL div1_len got=%0d exp=16", n); end
    checks++; if (rx_data1 !== 8'hFF) begin failures++; $display("FAIL div1_rx got=%h exp=ff", rx_data1); end
    checks++; if (status1 !== 16'h0012) begin failures++; $display("FAIL div1_status got=%h exp=0012", status1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_overrun();
    test_simul();
    test_rd_complete();
    test_reset_mid();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
